rca32_share_arb: RTL and testbench
==================================

// Module: rca32_share_arb
// PURPOSE
//   Shares one 32-bit ripple-carry adder (rca32) among NREQ requesters of the complex-multiplier
//   datapath (partial-product adds for real/imag parts). Round-robin arbitration, valid/ready
//   handshake per requester, one accepted add per cycle, result registered with requester ID.
//   Sits between the Vedic partial-product stages and the single shared rca32 instance.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   IDW   2  ID width, = clog2(NREQ); must match NREQ
// PORTS
//   clk        in   1         single clock, all state on rising edge
//   rst_n      in   1         synchronous reset, active low
//   req_valid  in   NREQ      per-requester operand valid
//   req_ready  out  NREQ      per-requester accept (one-hot or zero)
//   req_a      in   32*NREQ   operand A, requester i at [32*i+31:32*i]
//   req_b      in   32*NREQ   operand B, same packing
//   req_cin    in   NREQ      carry-in per requester
//   req_sub    in   NREQ      subtract select (used only with RCA_ARB_SUB_EN)
//   rsp_valid  out  1         result register holds a result
//   rsp_ready  in   1         downstream accepts result
//   rsp_id     out  IDW       index of requester that issued the result
//   rsp_sum    out  32        sum
//   rsp_cout   out  1         carry-out
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, last-grant
//     pointer = NREQ-1 (req0 has top priority). Reset mid-transaction discards held result.
//   - accept = !rsp_valid | rsp_ready (single-entry output reg; drain and refill in same cycle).
//   - Grant: first i with req_valid[i], searching from (ptr+1) mod NREQ upward with wrap.
//     req_ready[i] = grant[i] & accept; combinational from req_valid/rsp_valid/rsp_ready.
//   - Transfer on req_valid[i] & req_ready[i]: next edge loads rsp_* from rca32(a_i,b_i,cin_i),
//     rsp_id=i, rsp_valid=1, ptr=i. Latency 1 cycle, throughput 1/cycle when rsp_ready=1.
//   - No transfer: ptr unchanged. rsp_valid clears on rsp_ready & !transfer; rsp_* hold while
//     rsp_valid & !rsp_ready (stable until handshake).
//   - Requesters hold valid and operands until ready; arbiter never grants a deasserted request.
//   - No valid requests: req_ready=0, nothing loaded.
//   - Arithmetic: plain modulo-2^32 add; rsp_cout = bit 32 of a+b+cin.
// CONFIGURATION
//   RCA_ARB_SUB_EN defined: req_sub[i]=1 feeds ~b_i and forces cin=1 (ignores req_cin[i]),
//     rsp_sum = a-b mod 2^32, rsp_cout=1 means no borrow.
//   RCA_ARB_SUB_EN undefined: req_sub ignored, add only, port kept for pin compatibility.
// STRUCTURE
//   - Package rca_arb_pkg: RCA_W=32, default NREQ/IDW, rsp field offsets.
//   - Sub-module rr_arb (NREQ req vector + ptr -> one-hot grant + encoded index); existing
//     rca32 instantiated once; operand mux, subtract inversion and output register local.
// TESTING
//   1 Reset: hold rst_n=0 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_*=0.
//   2 Single add: req0 a=0xFFFF_FFFF b=1 cin=0, rsp_ready=1 -> next cycle rsp_sum=0, cout=1, id=0.
//   3 Round-robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one/cycle.
//   4 Backpressure: rsp_ready=0 with rsp_valid=1 -> req_ready=0, rsp_* stable 5 cycles; raise
//     rsp_ready -> drain and next grant same cycle.
//   5 Sub (RCA_ARB_SUB_EN): req2 a=5 b=7 sub=1 -> rsp_sum=0xFFFF_FFFE, cout=0, id=2; without
//     macro -> rsp_sum=12.
//   6 Reset mid-op: rsp_valid=1, rsp_ready=0, assert rst_n=0 -> next cycle rsp_valid=0, req0
//     wins next grant.

Source files
------------

// File: rtl/rca_arb_pkg.sv
// Shared constants for the rca32 sharing arbiter: datapath width, default
// requester count / ID width, and the bit layout of the packed response register.
package rca_arb_pkg;

   localparam int RCA_W    = 32;
   localparam int NREQ_DEF = 4;
   localparam int IDW_DEF  = 2;

   // Response register layout: {id, cout, sum}
   localparam int RSP_SUM_LSB  = 0;
   localparam int RSP_COUT_BIT = RCA_W;
   localparam int RSP_ID_LSB   = RCA_W + 1;

   // Total width of the packed response register for a given ID width
   function automatic int rsp_width(input int idw);
      return RCA_W + 1 + idw;
   endfunction

endpackage

// File: rtl/rca32.sv
// 32-bit ripple-carry adder: a chain of full adders from bit 0 upward.
module rca32
   import rca_arb_pkg::*;
(
   input  logic [RCA_W-1:0] i_a,
   input  logic [RCA_W-1:0] i_b,
   input  logic             i_cin,
   output logic [RCA_W-1:0] o_sum,
   output logic             o_cout
);

   // Bit-serial carry propagation through the full-adder chain
   always_comb begin
      logic [RCA_W:0] carry;
      carry    = '0;
      carry[0] = i_cin;
      o_sum    = '0;
      for (int i = 0; i < RCA_W; i++) begin
         o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
         carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
      end
      o_cout = carry[RCA_W];
   end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: searches the request vector starting one position
// after the last-grant pointer, wrapping modulo NREQ, and returns a one-hot
// grant, its encoded index and whether any request was found.
module rr_arb
   import rca_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
)
(
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   // First active request after the pointer, with wrap-around
   always_comb begin
      logic [IDW-1:0] cand;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(i_ptr) + k) % NREQ);
         if (!o_any && i_req[cand]) begin
            o_any         = 1'b1;
            o_grant[cand] = 1'b1;
            o_idx         = cand;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/rca32_share_arb.sv
// Shares a single rca32 among NREQ requesters with round-robin arbitration,
// per-requester valid/ready, and a single-entry registered response tagged
// with the requester ID. Accepts one add per cycle; the response register
// can drain and refill in the same cycle.
// Optional build macro: RCA_ARB_SUB_EN enables per-requester subtraction
// (req_sub selects a - b); without it req_sub is ignored.
module rca32_share_arb
   import rca_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [RCA_W*NREQ-1:0] req_a,
   input  logic [RCA_W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   input  logic [NREQ-1:0]       req_sub,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [RCA_W-1:0]      rsp_sum,
   output logic                  rsp_cout
);

   localparam int RSP_W = rsp_width(IDW);

   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_any;
   logic             w_accept;
   logic             w_xfer;
   logic [RCA_W-1:0] w_op_a;
   logic [RCA_W-1:0] w_op_b;
   logic             w_cin;
   logic [RCA_W-1:0] w_sum;
   logic             w_cout;

   logic [IDW-1:0]   r_ptr;
   logic             r_rsp_valid;
   logic [RSP_W-1:0] r_rsp;

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Output register can take a new result when empty or being drained;
   // nothing is accepted while reset is held so no request sees a ready.
   assign w_accept  = rst_n & (~r_rsp_valid | rsp_ready);
   assign w_xfer    = w_any & w_accept;
   assign req_ready = w_grant & {NREQ{w_accept}};

`ifdef RCA_ARB_SUB_EN
   // Operand mux for the granted requester; subtract inverts B and forces carry-in
   always_comb begin
      w_op_a = req_a[int'(w_idx)*RCA_W +: RCA_W];
      if (req_sub[w_idx]) begin
         w_op_b = ~req_b[int'(w_idx)*RCA_W +: RCA_W];
         w_cin  = 1'b1;
      end else begin
         w_op_b = req_b[int'(w_idx)*RCA_W +: RCA_W];
         w_cin  = req_cin[w_idx];
      end
   end
`else
   logic w_unused_sub;
   assign w_unused_sub = ^req_sub;

   // Operand mux for the granted requester; add only
   always_comb begin
      w_op_a = req_a[int'(w_idx)*RCA_W +: RCA_W];
      w_op_b = req_b[int'(w_idx)*RCA_W +: RCA_W];
      w_cin  = req_cin[w_idx];
   end
`endif

   rca32 u_rca (
      .i_a    (w_op_a),
      .i_b    (w_op_b),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Response register and last-grant pointer; result held until handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
         r_ptr       <= IDW'(NREQ - 1);
      end else if (w_xfer) begin
         r_rsp_valid <= 1'b1;
         r_rsp       <= {w_idx, w_cout, w_sum};
         r_ptr       <= w_idx;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= r_rsp_valid;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_rsp[RSP_SUM_LSB +: RCA_W];
   assign rsp_cout  = r_rsp[RSP_COUT_BIT];
   assign rsp_id    = r_rsp[RSP_ID_LSB +: IDW];

endmodule

// File: tb/tb_rca32_share_arb.sv
// Self-checking bench for rca32_share_arb (NREQ=4): hand sequences for reset,
// round-robin, backpressure and reset mid-transaction, a constant vector
// table, and randomized traffic against a cycle-level reference model.
module tb_rca32_share_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]  req_cin;
   logic [NREQ-1:0]  req_sub;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [31:0]      rsp_sum;
   logic             rsp_cout;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit          m_valid;
   int          m_id;
   logic [31:0] m_sum;
   bit          m_cout;
   int          m_ptr;

   always #5 clk = ~clk;

   rca32_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Round-robin choice: first valid requester after the pointer, wrapping
   function automatic int model_grant();
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (m_ptr + k) % NREQ;
         if (req_valid[c] === 1'b1) return c;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] model_ready();
      logic [NREQ-1:0] r;
      int g;
      r = '0;
      g = model_grant();
      if (rst_n === 1'b1 && g >= 0 && (!m_valid || rsp_ready === 1'b1)) r[g] = 1'b1;
      return r;
   endfunction

   // Arithmetic result for requester i: {cout, sum}
   function automatic logic [32:0] model_op(input int i);
      logic [31:0] a, b;
      logic        ci;
      a  = req_a[32*i +: 32];
      b  = req_b[32*i +: 32];
      ci = req_cin[i];
`ifdef RCA_ARB_SUB_EN
      if (req_sub[i]) begin
         b  = ~b;
         ci = 1'b1;
      end
`endif
      return {1'b0, a} + {1'b0, b} + {32'd0, ci};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 0;
      m_sum   = 32'd0;
      m_cout  = 1'b0;
      m_ptr   = NREQ - 1;
   endtask

   // Compare DUT against model, advance one clock, update model.
   task automatic cycle();
      int g;
      logic [NREQ-1:0] rdy;
      logic [32:0] t;
      #1;
      g   = model_grant();
      rdy = model_ready();
      t   = (g >= 0) ? model_op(g) : 33'd0;
      check("m_req_ready", req_ready, rdy);
      check("m_rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         check("m_rsp_id", rsp_id, m_id);
         check("m_rsp_sum", rsp_sum, m_sum);
         check("m_rsp_cout", rsp_cout, m_cout);
      end
      @(posedge clk);
      if (rst_n !== 1'b1) model_reset();
      else if (rdy != '0) begin
         m_valid = 1'b1;
         m_id    = g;
         m_ptr   = g;
         m_sum   = t[31:0];
         m_cout  = t[32];
      end else if (rsp_ready === 1'b1) m_valid = 1'b0;
      #1;
   endtask

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
   } vec_t;

   initial begin
      vec_t tbl[8];
      logic [NREQ-1:0] rr_exp[5];
      int   rr_id[5];
      logic [NREQ-1:0] hold;
      logic [NREQ-1:0] one;

      tbl[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
      tbl[1] = '{1, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0};
      tbl[2] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1};
      tbl[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
      tbl[4] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
      tbl[5] = '{2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
`ifdef RCA_ARB_SUB_EN
      tbl[6] = '{2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
      tbl[7] = '{0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1};
`else
      tbl[6] = '{2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0};
      tbl[7] = '{0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_000C, 1'b0};
`endif
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_id  = '{0, 1, 2, 3, 0};

      // Reset held with all requests valid
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      req_cin   = 4'h0;
      req_sub   = 4'h0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = $urandom;
         req_b[32*i +: 32] = $urandom;
      end
      @(posedge clk);
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("reset_ready", req_ready, 4'h0);
         cycle();
         check("reset_valid", rsp_valid, 1'b0);
         check("reset_id", rsp_id, 2'd0);
         check("reset_sum", rsp_sum, 32'd0);
         check("reset_cout", rsp_cout, 1'b0);
      end

      // Round-robin with all requesters valid and no backpressure
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("rr_grant", req_ready, rr_exp[i]);
         cycle();
         check("rr_id", rsp_id, rr_id[i]);
         check("rr_valid", rsp_valid, 1'b1);
      end

      // Constant vectors, one requester at a time
      foreach (tbl[v]) begin
         req_valid = 4'h0;
         req_sub   = 4'h0;
         req_cin   = 4'h0;
         req_valid[tbl[v].idx] = 1'b1;
         req_sub[tbl[v].idx]   = tbl[v].sub;
         req_cin[tbl[v].idx]   = tbl[v].cin;
         req_a[32*tbl[v].idx +: 32] = tbl[v].a;
         req_b[32*tbl[v].idx +: 32] = tbl[v].b;
         one = 4'h0;
         one[tbl[v].idx] = 1'b1;
         #1;
         check("tbl_ready", req_ready, one);
         cycle();
         check("tbl_valid", rsp_valid, 1'b1);
         check("tbl_id", rsp_id, tbl[v].idx);
         check("tbl_sum", rsp_sum, tbl[v].sum);
         check("tbl_cout", rsp_cout, tbl[v].cout);
      end

      // Backpressure: load req1, stall 5 cycles, then drain and refill together
      req_sub   = 4'h0;
      req_cin   = 4'h0;
      req_valid = 4'b0010;
      req_a[32*1 +: 32] = 32'hDEAD_0000;
      req_b[32*1 +: 32] = 32'h0000_BEEF;
      cycle();
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_ready", req_ready, 4'h0);
         cycle();
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_sum", rsp_sum, 32'hDEAD_BEEF);
         check("bp_id", rsp_id, 2'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_drain_ready", req_ready, 4'b0100);
      cycle();
      check("bp_next_id", rsp_id, 2'd2);

      // Reset while holding a result under backpressure
      rsp_ready = 1'b0;
      cycle();
      check("rst_mid_pre", rsp_valid, 1'b1);
      rst_n = 1'b0;
      cycle();
      check("rst_mid_valid", rsp_valid, 1'b0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("rst_mid_ready", req_ready, 4'b0001);
      cycle();
      check("rst_mid_id", rsp_id, 2'd0);

      // Randomized traffic; pending requests hold valid and operands
      hold = 4'h0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!hold[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_a[32*i +: 32] = $urandom;
               req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
               req_cin[i] = $urandom_range(0, 1);
               req_sub[i] = $urandom_range(0, 1);
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         rst_n     = ($urandom_range(0, 59) != 0);
         one  = model_ready();
         hold = req_valid & ~one;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
